checkpoint_sequence_monitor: RTL
================================

// Module: checkpoint_sequence_monitor
// PURPOSE
//  Parametrised checkpoint monitor for the DV benches. Watches a WIDTH-bit
//  checkbit bus (e.g. mprj_io[31:16]) for NUM_CHK expected codes in strict order.
//  Adds a per-run cycle timeout, a glitch filter, an explicit fail code and
//  status outputs, so each test no longer hand-codes wait/timeout logic.
// PARAMETERS
//  WIDTH          16     checkbit bus width (>=1)
//  NUM_CHK        2      number of ordered checkpoints (>=1)
//  TIMEOUT_CYCLES 70000  cycles allowed from run start to final checkpoint (>=1)
//  STABLE_CYCLES  1      consecutive matching samples required per hit (>=1)
// PORTS
//  clock      in   1                  single clock; all state on posedge
//  resetb     in   1                  asynchronous, active-low reset
//  enable     in   1                  1 = run; 0 = abort/return to IDLE
//  checkbits  in   WIDTH              monitored bus, sampled each posedge
//  exp_codes  in   NUM_CHK*WIDTH      code k at [k*WIDTH +: WIDTH]; code 0 first
//  fail_code  in   WIDTH              code signalling firmware-detected failure
//  fail_en    in   1                  1 = fail_code checking active
//  stage      out  $clog2(NUM_CHK+1)  number of checkpoints hit so far
//  hit        out  1                  1-cycle pulse when a checkpoint is hit
//  busy       out  1                  1 while in WAIT
//  passed     out  1                  sticky: all checkpoints hit
//  failed     out  1                  sticky: fail_code seen
//  timed_out  out  1                  sticky: timeout expired
//  cycles     out  $clog2(TIMEOUT_CYCLES+1)  cycles elapsed in current/last run
// BEHAVIOUR
//  Reset (resetb=0, async): state=IDLE; stage, hit, busy, passed, failed,
//   timed_out, cycles and the internal stability counter all 0.
//  States: IDLE, WAIT, PASS, FAIL, TIMEOUT.
//  IDLE: enable=1 -> WAIT; cycles, stage, stability counter and sticky flags cleared.
//  WAIT: busy=1. cycles increments each edge and saturates at TIMEOUT_CYCLES.
//   match = (checkbits == exp_codes[stage]); only the current stage's code counts,
//   so out-of-order codes are ignored. The stability counter increments
//   while match holds and clears to 0 on any non-match edge.
//   On the edge where the counter reaches STABLE_CYCLES: stage+1, hit=1 for
//   one cycle, counter cleared. If that was stage NUM_CHK-1 -> PASS, passed=1.
//   Codes: the filter applies per checkpoint. Repeated identical codes across
//   stages need a non-matching value between them only if STABLE_CYCLES
//   logic requires it. Equal consecutive codes are allowed; the counter restarts.
//   fail: fail_en=1 and checkbits==fail_code for STABLE_CYCLES edges -> FAIL,
//   failed=1. If fail_code equals the current expected code, the expected match wins.
//   timeout: cycles==TIMEOUT_CYCLES with no final hit -> TIMEOUT, timed_out=1.
//   Priority on the same edge: final hit > fail > timeout.
//  PASS/FAIL/TIMEOUT: terminal. Outputs hold (stage, cycles frozen). busy=0.
//   enable=0 -> IDLE (flags kept until the next run starts).
//  enable=0 while in WAIT: abort -> IDLE, busy=0, no flag set, stage and cycles hold.
//  Exactly one of passed/failed/timed_out is 1 after a completed run.
//  X/Z on checkbits is a non-match (use ===).
// TESTING
//  1 NUM_CHK=2, codes {AB41,AB40}: bus 0 -> AB40 @100 -> AB41 @500 -> hit pulses
//    at both, stage 1 then 2, passed=1, cycles~=500.
//  2 TIMEOUT_CYCLES=100, bus stuck at AB40 -> stage=1, timed_out=1 at cycle 100, busy=0.
//  3 fail_en=1, fail_code=AB4F: bus AB40 then AB4F -> failed=1, stage=1, passed=0.
//  4 STABLE_CYCLES=3: AB40 held for 2 cycles, then 0 -> no hit. Held 3 -> hit on
//    the 3rd edge.
//  5 Out-of-order: AB41 before AB40 -> stage stays 0. Then AB40, AB41 -> passed.
//  6 resetb low mid-WAIT (stage=1) -> all outputs 0 immediately (async). enable
//    held high -> new run starts after release.

Source files
------------

// File: rtl/checkpoint_sequence_monitor.sv
// -----------------------------------------------------------------------------
// checkpoint_sequence_monitor
//
// Watches a WIDTH-bit checkbit bus for NUM_CHK expected codes that must arrive
// in strict order. Each checkpoint must be seen on STABLE_CYCLES consecutive
// clock edges before it counts. The run ends in one of three sticky outcomes:
//   - passed    : every checkpoint was hit
//   - failed    : the fail code was seen (while fail checking is enabled)
//   - timed_out : TIMEOUT_CYCLES elapsed before the final checkpoint
// Only the current stage's code is compared, so codes that arrive out of order
// are ignored.
//
// Ports
//   clock      in   single clock, all state updates on posedge
//   resetb     in   asynchronous active-low reset
//   enable     in   1 = run, 0 = abort / return to idle
//   checkbits  in   monitored bus, sampled on every posedge
//   exp_codes  in   code k at [k*WIDTH +: WIDTH], code 0 is expected first
//   fail_code  in   code that signals a firmware-detected failure
//   fail_en    in   1 = fail_code checking active
//   stage      out  number of checkpoints hit so far
//   hit        out  one-cycle pulse after each checkpoint hit
//   busy       out  1 while a run is in progress
//   passed     out  sticky: all checkpoints hit
//   failed     out  sticky: fail code seen
//   timed_out  out  sticky: cycle budget exhausted
//   cycles     out  cycles elapsed in the current or last run
// -----------------------------------------------------------------------------
module checkpoint_sequence_monitor #(
   parameter int WIDTH          = 16,
   parameter int NUM_CHK        = 2,
   parameter int TIMEOUT_CYCLES = 70000,
   parameter int STABLE_CYCLES  = 1
) (
   input  logic                                 clock,
   input  logic                                 resetb,
   input  logic                                 enable,
   input  logic [WIDTH-1:0]                     checkbits,
   input  logic [NUM_CHK*WIDTH-1:0]             exp_codes,
   input  logic [WIDTH-1:0]                     fail_code,
   input  logic                                 fail_en,
   output logic [$clog2(NUM_CHK+1)-1:0]         stage,
   output logic                                 hit,
   output logic                                 busy,
   output logic                                 passed,
   output logic                                 failed,
   output logic                                 timed_out,
   output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]  cycles
);

   localparam int STG_W = $clog2(NUM_CHK + 1);
   localparam int CYC_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int STB_W = $clog2(STABLE_CYCLES + 1);

   localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_CHK - 1);
   localparam logic [CYC_W-1:0] CYC_LIMIT  = CYC_W'(TIMEOUT_CYCLES);
   localparam logic [STB_W-1:0] STB_LIMIT  = STB_W'(STABLE_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT    = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [STG_W-1:0]   stage_q, stage_d;
   logic [CYC_W-1:0]   cycles_q, cycles_d;
   logic [STB_W-1:0]   stb_q, stb_d;      // consecutive matches of the current code
   logic [STB_W-1:0]   fcnt_q, fcnt_d;    // consecutive matches of the fail code
   logic               hit_q, hit_d;
   logic               passed_q, passed_d;
   logic               failed_q, failed_d;
   logic               timed_out_q, timed_out_d;

   logic [WIDTH-1:0]   code_arr [NUM_CHK];
   logic [WIDTH-1:0]   exp_cur;
   logic               code_match, fail_match;
   logic               stb_hit, fail_hit, final_hit, tmo_hit;
   logic [CYC_W-1:0]   cycles_inc;

   generate
      for (genvar gi = 0; gi < NUM_CHK; gi++) begin : g_code
         assign code_arr[gi] = exp_codes[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Code for the current stage; stage never reaches NUM_CHK while waiting.
   always_comb begin
      exp_cur = '0;
      for (int k = 0; k < NUM_CHK; k++) begin
         if (stage_q == STG_W'(k)) exp_cur = code_arr[k];
      end
   end

   // Case equality keeps X/Z on the bus from ever counting as a match.
   // The expected code takes precedence when it equals the fail code.
   assign code_match = (checkbits === exp_cur);
   assign fail_match = fail_en && (checkbits === fail_code) && !code_match;
   assign stb_hit    = code_match && ((stb_q + STB_W'(1)) == STB_LIMIT);
   assign fail_hit   = fail_match && ((fcnt_q + STB_W'(1)) == STB_LIMIT);
   assign final_hit  = stb_hit && (stage_q == LAST_STAGE);
   assign cycles_inc = (cycles_q == CYC_LIMIT) ? cycles_q : cycles_q + CYC_W'(1);
   assign tmo_hit    = (cycles_inc == CYC_LIMIT);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   // Same-edge priority is final hit, then fail, then timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (enable) state_d = S_WAIT;
         S_WAIT: begin
            if (!enable)        state_d = S_IDLE;
            else if (final_hit) state_d = S_PASS;
            else if (fail_hit)  state_d = S_FAIL;
            else if (tmo_hit)   state_d = S_TIMEOUT;
         end
         default: if (!enable) state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy      = (state_q == S_WAIT);
      stage     = stage_q;
      hit       = hit_q;
      passed    = passed_q;
      failed    = failed_q;
      timed_out = timed_out_q;
      cycles    = cycles_q;
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      stage_d     = stage_q;
      cycles_d    = cycles_q;
      stb_d       = stb_q;
      fcnt_d      = fcnt_q;
      hit_d       = 1'b0;
      passed_d    = passed_q;
      failed_d    = failed_q;
      timed_out_d = timed_out_q;
      case (state_q)
         S_IDLE: begin
            // Outcome flags survive in idle and are only cleared by a new run.
            if (enable) begin
               stage_d     = '0;
               cycles_d    = '0;
               stb_d       = '0;
               fcnt_d      = '0;
               passed_d    = 1'b0;
               failed_d    = 1'b0;
               timed_out_d = 1'b0;
            end
         end
         S_WAIT: begin
            // On abort stage and cycles hold so the partial run stays visible.
            if (enable) begin
               cycles_d = cycles_inc;
               if (stb_hit) begin
                  stb_d   = '0;
                  stage_d = stage_q + STG_W'(1);
                  hit_d   = 1'b1;
               end else if (code_match) begin
                  stb_d = stb_q + STB_W'(1);
               end else begin
                  stb_d = '0;
               end
               if (fail_match) fcnt_d = fail_hit ? '0 : fcnt_q + STB_W'(1);
               else            fcnt_d = '0;
               passed_d    = final_hit;
               failed_d    = fail_hit && !final_hit;
               timed_out_d = tmo_hit && !final_hit && !fail_hit;
            end
         end
         default: ;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         stage_q     <= '0;
         cycles_q    <= '0;
         stb_q       <= '0;
         fcnt_q      <= '0;
         hit_q       <= 1'b0;
         passed_q    <= 1'b0;
         failed_q    <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         stage_q     <= stage_d;
         cycles_q    <= cycles_d;
         stb_q       <= stb_d;
         fcnt_q      <= fcnt_d;
         hit_q       <= hit_d;
         passed_q    <= passed_d;
         failed_q    <= failed_d;
         timed_out_q <= timed_out_d;
      end
   end

endmodule
